wb_commit_stage: RTL and testbench

//  Consumer end of the execute-result interface: accepts EXE results (rd data, rd addr, inst type, pc)

---
 rtl/wb_commit_stage_pkg.sv | 20 ++
 rtl/wb_regfile.sv | 56 +++++
 rtl/wb_commit_stage.sv | 121 ++++++++++++
 tb/tb_wb_commit_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_commit_stage_pkg.sv
// Shared widths, WB occupancy states and the register-write qualifier for the WB commit slice.
package wb_commit_stage_pkg;

    localparam int XLEN_DEF    = 64;
    localparam int NREG_DEF    = 32;
    localparam int CNT_W_DEF   = 64;
    localparam int REG_ADDR_W  = 5;
    localparam int INST_TYPE_W = 5;

    typedef enum logic {
        WB_EMPTY = 1'b0,
        WB_HELD  = 1'b1
    } wb_state_e;

    // x0 is hard-wired to zero, so a write aimed at it never reaches the array.
    function automatic logic rf_write_en(input logic rd_wen, input logic [REG_ADDR_W-1:0] rd_addr);
        return rd_wen && (rd_addr != '0);
    endfunction

endpackage

// File: rtl/wb_regfile.sv
// Architectural register file: 1 write port, 2 async read ports, x0 reads as zero.
// Define WB_BYPASS_EN to forward the committing write to the read ports in the same cycle.
module wb_regfile
    import wb_commit_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data
);

    logic [XLEN-1:0] rf_q [NREG];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_write_en(wen, waddr)) begin
            rf_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rs1_data = '0;
        if (rs1_addr != '0) begin
            rs1_data = rf_q[rs1_addr];
`ifdef WB_BYPASS_EN
            if (rf_write_en(wen, waddr) && (waddr == rs1_addr)) begin
                rs1_data = wdata;
            end
`endif
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr != '0) begin
            rs2_data = rf_q[rs2_addr];
`ifdef WB_BYPASS_EN
            if (rf_write_en(wen, waddr) && (waddr == rs2_addr)) begin
                rs2_data = wdata;
            end
`endif
        end
    end

endmodule

// File: rtl/wb_commit_stage.sv
// Write-back stage: accepts EXE results, holds one instruction, commits it to the register file
// and counts retirements. Optional same-cycle read forwarding is enabled by defining WB_BYPASS_EN.
module wb_commit_stage
    import wb_commit_stage_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_valid,
    output logic                   ex_ready,
    input  logic                   ex_rd_wen,
    input  logic [REG_ADDR_W-1:0]  ex_rd_addr,
    input  logic [XLEN-1:0]        ex_rd_data,
    input  logic [INST_TYPE_W-1:0] ex_inst_type,
    input  logic [XLEN-1:0]        ex_pc,
    input  logic                   wb_stall,
    input  logic                   flush,
    input  logic [REG_ADDR_W-1:0]  rs1_addr,
    input  logic [REG_ADDR_W-1:0]  rs2_addr,
    output logic [XLEN-1:0]        rs1_data,
    output logic [XLEN-1:0]        rs2_data,
    output logic                   commit_valid,
    output logic [XLEN-1:0]        commit_pc,
    output logic [INST_TYPE_W-1:0] commit_inst_type,
    output logic [CNT_W-1:0]       instret
);

    wb_state_e              state_q, state_d;
    logic                   wb_valid;
    logic                   accept;
    logic                   wb_rd_wen_q;
    logic [REG_ADDR_W-1:0]  wb_rd_addr_q;
    logic [XLEN-1:0]        wb_rd_data_q;
    logic [INST_TYPE_W-1:0] wb_inst_type_q;
    logic [XLEN-1:0]        wb_pc_q;
    logic [CNT_W-1:0]       instret_q;

    assign wb_valid = (state_q == WB_HELD);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= WB_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A held slot can take a new instruction only in the cycle it commits (back-to-back flow).
    always_comb begin
        state_d      = state_q;
        ex_ready     = 1'b0;
        commit_valid = 1'b0;
        accept       = 1'b0;

        ex_ready     = rst & ~flush & (~wb_valid | ~wb_stall);
        commit_valid = rst & wb_valid & ~wb_stall & ~flush;
        accept       = ex_valid & ex_ready;

        case (state_q)
            WB_EMPTY: begin
                if (accept) state_d = WB_HELD;
            end
            WB_HELD: begin
                if (flush) begin
                    state_d = WB_EMPTY;
                end else if (commit_valid && !accept) begin
                    state_d = WB_EMPTY;
                end
            end
            default: state_d = WB_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_rd_wen_q    <= 1'b0;
            wb_rd_addr_q   <= '0;
            wb_rd_data_q   <= '0;
            wb_inst_type_q <= '0;
            wb_pc_q        <= '0;
        end else if (accept) begin
            wb_rd_wen_q    <= ex_rd_wen;
            wb_rd_addr_q   <= ex_rd_addr;
            wb_rd_data_q   <= ex_rd_data;
            wb_inst_type_q <= ex_inst_type;
            wb_pc_q        <= ex_pc;
        end
    end

    // Retirement counter wraps naturally at 2^CNT_W; writes to x0 still count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            instret_q <= '0;
        end else if (commit_valid) begin
            instret_q <= instret_q + 1'b1;
        end
    end

    assign instret          = instret_q;
    assign commit_pc        = wb_valid ? wb_pc_q : '0;
    assign commit_inst_type = wb_valid ? wb_inst_type_q : '0;

    wb_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .wen      (commit_valid & wb_rd_wen_q),
        .waddr    (wb_rd_addr_q),
        .wdata    (wb_rd_data_q),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage: table-driven back-to-back flow plus reset, stall, flush,
// same-cycle read (WB_BYPASS_EN aware) and instret wrap sequences.
module tb_wb_commit_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_rd_wen;
    logic [4:0]  ex_rd_addr;
    logic [63:0] ex_rd_data;
    logic [4:0]  ex_inst_type;
    logic [63:0] ex_pc;
    logic        wb_stall;
    logic        flush;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic [4:0]  commit_inst_type;
    logic [63:0] instret;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_commit_stage dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid         (ex_valid),
        .ex_ready         (ex_ready),
        .ex_rd_wen        (ex_rd_wen),
        .ex_rd_addr       (ex_rd_addr),
        .ex_rd_data       (ex_rd_data),
        .ex_inst_type     (ex_inst_type),
        .ex_pc            (ex_pc),
        .wb_stall         (wb_stall),
        .flush            (flush),
        .rs1_addr         (rs1_addr),
        .rs2_addr         (rs2_addr),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .commit_valid     (commit_valid),
        .commit_pc        (commit_pc),
        .commit_inst_type (commit_inst_type),
        .instret          (instret)
    );

    typedef struct {
        logic        valid;
        logic        wen;
        logic [4:0]  addr;
        logic [63:0] data;
        logic [4:0]  itype;
        logic [63:0] pc;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        exp_ready;
        logic        exp_commit;
        logic [63:0] exp_pc;
        logic [4:0]  exp_type;
        logic [63:0] exp_rs1;
        logic [63:0] exp_rs2;
        logic [63:0] exp_instret;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [63:0] d,
                         input logic [4:0] t, input logic [63:0] p);
        ex_valid     = v;
        ex_rd_wen    = 1'b1;
        ex_rd_addr   = a;
        ex_rd_data   = d;
        ex_inst_type = t;
        ex_pc        = p;
    endtask

    logic [63:0] exp_byp;

    initial begin
        rst = 1'b0;
        drive(1'b1, 5'd5, 64'h99, 5'd1, 64'h80);
        wb_stall = 1'b0;
        flush    = 1'b0;
        rs1_addr = 5'd5;
        rs2_addr = 5'd0;

        // Reset held two cycles with ex_valid asserted.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("reset_ex_ready", {63'd0, ex_ready}, 64'd0);
            chk("reset_commit_valid", {63'd0, commit_valid}, 64'd0);
            chk("reset_instret", instret, 64'd0);
            chk("reset_rs1_x5", rs1_data, 64'd0);
        end
        tick();
        rst = 1'b1;
        ex_valid = 1'b0;

        // Back-to-back: x1=0xA, x2=0xB, x0=0xC, then drain.
        vecs[0] = '{1'b1, 1'b1, 5'd1, 64'hA, 5'd1, 64'h100, 5'd1, 5'd2,
                    1'b1, 1'b0, 64'h0,   5'd0, 64'h0, 64'h0, 64'd0};
        vecs[1] = '{1'b1, 1'b1, 5'd2, 64'hB, 5'd2, 64'h104, 5'd0, 5'd0,
                    1'b1, 1'b1, 64'h100, 5'd1, 64'h0, 64'h0, 64'd0};
        vecs[2] = '{1'b1, 1'b1, 5'd0, 64'hC, 5'd3, 64'h108, 5'd1, 5'd0,
                    1'b1, 1'b1, 64'h104, 5'd2, 64'hA, 64'h0, 64'd1};
        vecs[3] = '{1'b0, 1'b0, 5'd0, 64'h0, 5'd0, 64'h0,   5'd2, 5'd1,
                    1'b1, 1'b1, 64'h108, 5'd3, 64'hB, 64'hA, 64'd2};
        vecs[4] = '{1'b0, 1'b0, 5'd0, 64'h0, 5'd0, 64'h0,   5'd0, 5'd2,
                    1'b1, 1'b0, 64'h0,   5'd0, 64'h0, 64'hB, 64'd3};

        for (int i = 0; i < 5; i++) begin
            ex_valid     = vecs[i].valid;
            ex_rd_wen    = vecs[i].wen;
            ex_rd_addr   = vecs[i].addr;
            ex_rd_data   = vecs[i].data;
            ex_inst_type = vecs[i].itype;
            ex_pc        = vecs[i].pc;
            rs1_addr     = vecs[i].ra1;
            rs2_addr     = vecs[i].ra2;
            @(negedge clk);
            chk($sformatf("vec%0d_ex_ready", i), {63'd0, ex_ready}, {63'd0, vecs[i].exp_ready});
            chk($sformatf("vec%0d_commit_valid", i), {63'd0, commit_valid}, {63'd0, vecs[i].exp_commit});
            chk($sformatf("vec%0d_commit_pc", i), commit_pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_commit_type", i), {59'd0, commit_inst_type}, {59'd0, vecs[i].exp_type});
            chk($sformatf("vec%0d_rs1", i), rs1_data, vecs[i].exp_rs1);
            chk($sformatf("vec%0d_rs2", i), rs2_data, vecs[i].exp_rs2);
            chk($sformatf("vec%0d_instret", i), instret, vecs[i].exp_instret);
            tick();
        end

        // Stall: x3=0x55 held four cycles, then released.
        drive(1'b1, 5'd3, 64'h55, 5'd4, 64'h200);
        rs1_addr = 5'd3;
        rs2_addr = 5'd0;
        tick();
        ex_valid = 1'b0;
        wb_stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("stall_ex_ready", {63'd0, ex_ready}, 64'd0);
            chk("stall_commit_valid", {63'd0, commit_valid}, 64'd0);
            chk("stall_x3", rs1_data, 64'h0);
            chk("stall_instret", instret, 64'd3);
            tick();
        end
        wb_stall = 1'b0;
        @(negedge clk);
        chk("stall_release_commit", {63'd0, commit_valid}, 64'd1);
        chk("stall_release_pc", commit_pc, 64'h200);
        tick();
        @(negedge clk);
        chk("stall_after_commit", {63'd0, commit_valid}, 64'd0);
        chk("stall_after_x3", rs1_data, 64'h55);
        chk("stall_after_instret", instret, 64'd4);

        // Flush: x4=0x77 held, flush with a new candidate x7 on the input.
        tick();
        drive(1'b1, 5'd4, 64'h77, 5'd5, 64'h300);
        rs1_addr = 5'd4;
        rs2_addr = 5'd7;
        tick();
        drive(1'b1, 5'd7, 64'h88, 5'd6, 64'h304);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_ex_ready", {63'd0, ex_ready}, 64'd0);
        chk("flush_commit_valid", {63'd0, commit_valid}, 64'd0);
        tick();
        flush = 1'b0;
        ex_valid = 1'b0;
        @(negedge clk);
        chk("flush_next_commit", {63'd0, commit_valid}, 64'd0);
        chk("flush_next_pc", commit_pc, 64'h0);
        chk("flush_x4", rs1_data, 64'h0);
        chk("flush_x7", rs2_data, 64'h0);
        chk("flush_instret", instret, 64'd4);
        tick();
        @(negedge clk);
        chk("flush_later_x4", rs1_data, 64'h0);
        chk("flush_later_instret", instret, 64'd4);

        // Same-cycle read of the committing register.
        tick();
        drive(1'b1, 5'd6, 64'h1234, 5'd7, 64'h400);
        rs1_addr = 5'd6;
        rs2_addr = 5'd0;
        tick();
        ex_valid = 1'b0;
`ifdef WB_BYPASS_EN
        exp_byp = 64'h1234;
`else
        exp_byp = 64'h0;
`endif
        @(negedge clk);
        chk("bypass_commit_valid", {63'd0, commit_valid}, 64'd1);
        chk("bypass_rs1_commit_cycle", rs1_data, exp_byp);
        tick();
        @(negedge clk);
        chk("bypass_rs1_next", rs1_data, 64'h1234);
        chk("bypass_instret", instret, 64'd5);

        // Counter wrap via backdoor preload.
        tick();
        dut.instret_q = '1;
        drive(1'b1, 5'd8, 64'h1, 5'd8, 64'h500);
        @(negedge clk);
        chk("wrap_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        ex_valid = 1'b0;
        @(negedge clk);
        chk("wrap_commit_valid", {63'd0, commit_valid}, 64'd1);
        tick();
        @(negedge clk);
        chk("wrap_instret", instret, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
